// File: rtl/matmul_scheduler.sv
// matmul_scheduler: sequences C = A x B over one shared inner_product unit.
//   clk, rst (async, active low)
//   start_i_stb/start_i_ack, a_in, b_in : latch operands and begin a run
//   c_out, done_o_stb/done_o_ack, err   : result matrix, completion handshake, timeout flag
//   busy                                : high outside IDLE
//   ip_row, ip_column, ip_*_stb/ack     : issue/result handshake with inner_product
module matmul_scheduler #(
    parameter int N = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i_stb,
    output logic              start_i_ack,
    input  logic [32*N*N-1:0] a_in,
    input  logic [32*N*N-1:0] b_in,
    output logic [32*N*N-1:0] c_out,
    output logic              done_o_stb,
    input  logic              done_o_ack,
    output logic              busy,
    output logic              err,
    output logic [32*N-1:0]   ip_row,
    output logic [32*N-1:0]   ip_column,
    output logic              ip_row_stb,
    output logic              ip_column_stb,
    output logic              ip_out_ack,
    input  logic              ip_row_ack,
    input  logic              ip_column_ack,
    input  logic              ip_out_stb,
    input  logic [31:0]       ip_out
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DRAIN, ISSUE, WAIT_ACK, WAIT_RES, NEXT, DONE} state_t;

    state_t state, state_n;
    logic [IW-1:0] i, j;
    logic [TW-1:0] tcnt;
    logic [N-1:0][N-1:0][31:0] a_q, b_q, c_q;
    logic timeout;

    always_comb begin
        state_n = state;
        timeout = 1'b0;
        case (state)
            IDLE:     if (start_i_stb) state_n = DRAIN;
            // wait for the unit to go fully quiet so a lingering result strobe is never re-captured
            DRAIN:    if (!ip_out_stb && !ip_row_ack && !ip_column_ack) state_n = ISSUE;
            ISSUE:    state_n = WAIT_ACK;
            WAIT_ACK: begin
                if (ip_row_ack && ip_column_ack) state_n = WAIT_RES;
                else if (tcnt == TLIM) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end
            end
            WAIT_RES: begin
                if (ip_out_stb) state_n = NEXT;
                else if (tcnt == TLIM) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end
            end
            NEXT:     state_n = (i == LAST && j == LAST) ? DONE : DRAIN;
            DONE:     if (done_o_ack) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
            tcnt <= '0;
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            err <= 1'b0;
            start_i_ack <= 1'b0;
        end else begin
            start_i_ack <= state == IDLE && start_i_stb;
            // counts only while parked in a wait state; any transition restarts it
            tcnt <= ((state == WAIT_ACK || state == WAIT_RES) && state_n == state) ? tcnt + 1'b1 : '0;
            if (state == IDLE && start_i_stb) begin
                a_q <= a_in;
                b_q <= b_in;
                c_q <= '0;
                err <= 1'b0;
                i <= '0;
                j <= '0;
            end
            if (state == WAIT_RES && ip_out_stb) c_q[i][j] <= ip_out;
            if (state == NEXT) begin
                j <= (j == LAST) ? '0 : j + 1'b1;
                i <= (j == LAST) ? i + 1'b1 : i;
            end
            if (timeout) err <= 1'b1;
        end
    end

    assign busy = state != IDLE;
    assign done_o_stb = state == DONE;
    assign ip_row_stb = state == ISSUE || state == WAIT_ACK;
    assign ip_column_stb = ip_row_stb;
    assign ip_out_ack = ip_row_stb || state == WAIT_RES;
    assign c_out = c_q;

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign ip_row[32*k +: 32] = ip_out_ack ? a_q[i][k] : 32'd0;
        assign ip_column[32*k +: 32] = ip_out_ack ? b_q[k][j] : 32'd0;
    end
endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: table, directed and random checks of matmul_scheduler against a reference product.
module tb_matmul_scheduler;
    localparam int N = 2;
    localparam int T = 16;
    localparam int W = 32 * N * N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_i_stb = 1'b0;
    logic start_i_ack;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] c_out;
    logic done_o_stb;
    logic done_o_ack = 1'b0;
    logic busy;
    logic err;
    logic [32*N-1:0] ip_row, ip_column;
    logic ip_row_stb, ip_column_stb, ip_out_ack;
    logic ip_row_ack, ip_column_ack, ip_out_stb;
    logic [31:0] ip_out;

    matmul_scheduler #(.N(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .start_i_stb(start_i_stb), .start_i_ack(start_i_ack),
        .a_in(a_in), .b_in(b_in), .c_out(c_out),
        .done_o_stb(done_o_stb), .done_o_ack(done_o_ack),
        .busy(busy), .err(err),
        .ip_row(ip_row), .ip_column(ip_column),
        .ip_row_stb(ip_row_stb), .ip_column_stb(ip_column_stb), .ip_out_ack(ip_out_ack),
        .ip_row_ack(ip_row_ack), .ip_column_ack(ip_column_ack),
        .ip_out_stb(ip_out_stb), .ip_out(ip_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] matmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] s;
        matmul = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < N; k++) s = s + a[32*(r*N+k) +: 32] * b[32*(k*N+c) +: 32];
                matmul[32*(r*N+c) +: 32] = s;
            end
    endfunction

    function automatic logic [31:0] dot(input logic [32*N-1:0] r, input logic [32*N-1:0] c);
        dot = 0;
        for (int k = 0; k < N; k++) dot = dot + r[32*k +: 32] * c[32*k +: 32];
    endfunction

    // inner_product stand-in: accept after ackd cycles, result lat cycles after strobes drop,
    // result strobe lingers sticky cycles after being consumed, or never appears when hang is set
    int lat = 3, sticky = 0, ackd = 0;
    logic hang = 1'b0;
    int m_st, m_cnt;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= 0;
            m_cnt <= 0;
            m_res <= 0;
            ip_row_ack <= 1'b0;
            ip_column_ack <= 1'b0;
            ip_out_stb <= 1'b0;
            ip_out <= 32'd0;
        end else begin
            case (m_st)
                0: if (ip_row_stb && ip_column_stb) begin
                    if (m_cnt >= ackd) begin
                        ip_row_ack <= 1'b1;
                        ip_column_ack <= 1'b1;
                        m_res <= dot(ip_row, ip_column);
                        m_cnt <= 0;
                        m_st <= 1;
                    end else m_cnt <= m_cnt + 1;
                end
                1: if (!ip_row_stb) begin
                    ip_row_ack <= 1'b0;
                    ip_column_ack <= 1'b0;
                    m_cnt <= lat;
                    m_st <= 2;
                end
                2: if (m_cnt > 1) m_cnt <= m_cnt - 1;
                   else if (hang) m_st <= 5;
                   else begin
                       ip_out_stb <= 1'b1;
                       ip_out <= m_res;
                       m_st <= 3;
                   end
                3: if (!ip_out_ack) begin
                    m_cnt <= sticky;
                    m_st <= 4;
                end
                4: if (m_cnt > 0) m_cnt <= m_cnt - 1;
                   else begin
                       ip_out_stb <= 1'b0;
                       m_st <= 0;
                   end
                5: if (!ip_out_ack) begin
                    m_cnt <= 0;
                    m_st <= 0;
                end
                default: m_st <= 0;
            endcase
        end
    end

    int issues = 0, bad_issue = 0, ack_pulses = 0, sack_wide = 0;
    logic prev_rstb = 1'b0, prev_sack = 1'b0;
    logic [127:0] issue_q[$];

    always @(negedge clk) begin
        if (rst && ip_row_stb && !prev_rstb) begin
            issues <= issues + 1;
            issue_q.push_back({ip_row, ip_column});
            if (ip_out_stb) bad_issue <= bad_issue + 1;
        end
        if (rst && start_i_ack) begin
            ack_pulses <= ack_pulses + 1;
            if (prev_sack) sack_wide <= sack_wide + 1;
        end
        prev_rstb <= ip_row_stb;
        prev_sack <= start_i_ack;
    end

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        a_in = a;
        b_in = b;
        start_i_stb = 1'b1;
        for (int n = 0; n < 10 && !start_i_ack; n++) begin
            @(posedge clk);
            #1;
        end
        check("start_ack", W'(start_i_ack), W'(1));
        start_i_stb = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int cyc);
        cyc = 0;
        while (!done_o_stb && cyc < lim) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", W'(done_o_stb), W'(1));
    endtask

    task automatic finish_run();
        done_o_ack = 1'b1;
        @(posedge clk);
        #1;
        done_o_ack = 1'b0;
        check("done_drop", W'(done_o_stb), W'(0));
    endtask

    typedef struct {
        logic [W-1:0] a, b, c;
        int lat, sticky, ackd;
    } vec_t;

    vec_t vecs[5];

    task automatic check_order(input int qb, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [32*N-1:0] r, c;
        for (int p = 0; p < N * N; p++) begin
            for (int k = 0; k < N; k++) begin
                r[32*k +: 32] = a[32*((p/N)*N+k) +: 32];
                c[32*k +: 32] = b[32*(k*N+(p%N)) +: 32];
            end
            check($sformatf("issue_%0d", p), W'(issue_q[qb+p]), W'({r, c}));
        end
    endtask

    initial begin
        int cyc, base, qb;
        logic [W-1:0] ra, rb;
        vecs[0] = '{{32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5},
                    {32'd50, 32'd43, 32'd22, 32'd19}, 3, 0, 0};
        vecs[1] = '{{32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5},
                    {32'd50, 32'd43, 32'd22, 32'd19}, 3, 4, 1};
        vecs[2] = '{{32'd1, 32'd0, 32'd0, 32'd1}, {32'd12, 32'd11, 32'd10, 32'd9},
                    {32'd12, 32'd11, 32'd10, 32'd9}, 1, 0, 2};
        vecs[3] = '{{32'd1, 32'd0, 32'd0, 32'hFFFFFFFF}, {32'd3, 32'd0, 32'd0, 32'd2},
                    {32'd3, 32'd0, 32'd0, 32'hFFFFFFFE}, 5, 2, 0};
        vecs[4] = '{{32'd5, 32'd4, 32'd3, 32'd2}, {32'd1, 32'd1, 32'd0, 32'd1},
                    {32'd5, 32'd9, 32'd3, 32'd5}, 2, 1, 3};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", W'({busy, done_o_stb, err, start_i_ack, ip_row_stb, ip_column_stb, ip_out_ack}), W'(0));
        check("reset_c", c_out, '0);
        check("reset_ip", W'({ip_row, ip_column}), W'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            lat = vecs[v].lat;
            sticky = vecs[v].sticky;
            ackd = vecs[v].ackd;
            base = issues;
            qb = issue_q.size();
            do_start(vecs[v].a, vecs[v].b);
            wait_done(500, cyc);
            check($sformatf("vec%0d_c", v), c_out, vecs[v].c);
            check($sformatf("vec%0d_err", v), W'(err), W'(0));
            check($sformatf("vec%0d_issues", v), W'(issues - base), W'(N * N));
            check_order(qb, vecs[v].a, vecs[v].b);
            if (v == 0) check("issue_01_pack", W'(issue_q[qb+1]), W'({32'd2, 32'd1, 32'd8, 32'd6}));
            finish_run();
        end
        check("no_issue_while_result", W'(bad_issue), W'(0));

        // timeout: the first result never arrives
        lat = 3; sticky = 0; ackd = 0; hang = 1'b1;
        do_start(vecs[0].a, vecs[0].b);
        cyc = 0;
        while (!(ip_out_ack && !ip_row_stb) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("to_wait_res", W'(ip_out_ack && !ip_row_stb), W'(1));
        wait_done(40, cyc);
        check("to_latency", W'(cyc >= T - 1 && cyc <= T), W'(1));
        check("to_err", W'(err), W'(1));
        check("to_c_zero", c_out, '0);
        check("to_ip_idle", W'({ip_row_stb, ip_column_stb, ip_out_ack}), W'(0));
        finish_run();
        check("to_err_hold", W'(err), W'(1));
        hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset while waiting on the (1,0) result
        lat = 6;
        base = issues;
        do_start(vecs[0].a, vecs[0].b);
        cyc = 0;
        while (!(issues - base == 3 && ip_out_ack && !ip_row_stb) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_reached_10", W'(issues - base == 3 && ip_out_ack && !ip_row_stb), W'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_ctrl", W'({busy, done_o_stb, err, ip_row_stb, ip_column_stb, ip_out_ack}), W'(0));
        check("rst_mid_c", c_out, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        lat = 3;
        do_start(vecs[4].a, vecs[4].b);
        wait_done(500, cyc);
        check("rst_rerun_c", c_out, vecs[4].c);
        finish_run();

        // start held high, delayed done ack
        base = ack_pulses;
        a_in = vecs[0].a;
        b_in = vecs[0].b;
        start_i_stb = 1'b1;
        wait_done(500, cyc);
        check("hs_c", c_out, vecs[0].c);
        check("hs_one_ack", W'(ack_pulses - base), W'(1));
        for (int d = 0; d < 5; d++) begin
            @(posedge clk);
            #1;
            check("hs_done_hold", W'(done_o_stb), W'(1));
        end
        done_o_ack = 1'b1;
        @(posedge clk);
        #1;
        done_o_ack = 1'b0;
        check("hs_done_fall", W'({done_o_stb, busy}), W'(0));
        @(posedge clk);
        #1;
        check("hs_restart", W'({busy, start_i_ack}), W'(2'b11));
        start_i_stb = 1'b0;
        wait_done(500, cyc);
        check("hs_c2", c_out, vecs[0].c);
        finish_run();
        @(negedge clk);
        check("hs_two_acks", W'(ack_pulses - base), W'(2));
        check("hs_ack_width", W'(sack_wide), W'(0));

        // random operands and unit timing against the reference product
        for (int t = 0; t < 20; t++) begin
            for (int w = 0; w < N * N; w++) begin
                ra[32*w +: 32] = (t % 2 == 0) ? $urandom() : $urandom_range(0, 15);
                rb[32*w +: 32] = (t % 2 == 0) ? $urandom() : $urandom_range(0, 15);
            end
            lat = $urandom_range(1, 8);
            sticky = $urandom_range(0, 5);
            ackd = $urandom_range(0, 3);
            base = issues;
            do_start(ra, rb);
            wait_done(500, cyc);
            check($sformatf("rnd%0d_c", t), c_out, matmul(ra, rb));
            check($sformatf("rnd%0d_err", t), W'(err), W'(0));
            check($sformatf("rnd%0d_issues", t), W'(issues - base), W'(N * N));
            finish_run();
        end
        check("rnd_no_issue_while_result", W'(bad_issue), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matmul_scheduler.md
Name: matmul_scheduler

Overview:
- Sequencing controller that computes C = A x B for N x N matrices of 32-bit words using one shared inner_product unit.
- Latches A and B on a start handshake, then issues every (row i of A, column j of B) pair to the unit in row-major order.
- Captures each dot product into C and signals completion with a strobe/ack handshake.
- Sits between the system-level matrix interface and a single inner_product instance.

Parameters:
- N, 4, matrix dimension and inner_product number_of_elements (N >= 1).
- TIMEOUT_CYCLES, 1024, maximum cycles allowed in WAIT_ACK or WAIT_RES before aborting.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- start_i_stb  input  1  request to start; A and B are valid while high.
- start_i_ack  output  1  one-cycle pulse when A and B are latched.
- a_in  input  32*N*N  matrix A; element (r,c) at word index r*N+c, word 0 at LSBs.
- b_in  input  32*N*N  matrix B, same packing as a_in.
- c_out  output  32*N*N  result matrix C, same packing as a_in.
- done_o_stb  output  1  result valid; held until done_o_ack.
- done_o_ack  input  1  consumer accepts the result.
- busy  output  1  high in every state except IDLE.
- err  output  1  timeout flag; valid while done_o_stb is high.
- ip_row  output  32*N  row i of A; element k at bits [32k+31:32k].
- ip_column  output  32*N  column j of B; element k = B(k,j), same packing as ip_row.
- ip_row_stb, ip_column_stb  output  1  issue strobes to inner_product.
- ip_out_ack  output  1  out_o_ack to inner_product.
- ip_row_ack, ip_column_ack  input  1  inner_product accept acks.
- ip_out_stb  input  1  inner_product result strobe.
- ip_out  input  32  inner_product result word.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, i = j = 0, timeout counter = 0.
  - All outputs 0, including c_out, err, and the latched A/B copies.
- IDLE:
  - When start_i_stb is high: latch a_in and b_in, clear c_out and err, i = j = 0, pulse start_i_ack for one cycle, go to DRAIN.
  - start_i_stb is ignored in every other state.
- DRAIN:
  - All ip strobes and ip_out_ack are low.
  - Stay until ip_out_stb == 0 and ip_row_ack == 0 and ip_column_ack == 0, i.e. the unit has returned to idle and cleared its flags.
  - Then go to ISSUE. Minimum stay is 1 cycle.
- ISSUE:
  - Drive ip_row and ip_column from the latched copies for the current (i, j).
  - Assert ip_row_stb, ip_column_stb and ip_out_ack. Clear the timeout counter. Go to WAIT_ACK.
- WAIT_ACK:
  - Hold the strobes and ip_out_ack high.
  - When ip_row_ack and ip_column_ack are both high: drop both strobes, keep ip_out_ack high, clear the timeout counter, go to WAIT_RES.
- WAIT_RES:
  - ip_row and ip_column stay stable.
  - On the first cycle ip_out_stb is high: write ip_out to C word i*N+j, drop ip_out_ack, go to NEXT.
- NEXT:
  - If j == N-1 then j = 0 and i = i+1; otherwise j = j+1.
  - If the finished pair was (N-1, N-1), go to DONE; otherwise go to DRAIN.
- Timeout:
  - The counter increments every cycle in WAIT_ACK and WAIT_RES.
  - When it reaches TIMEOUT_CYCLES-1 without the awaited event: set err = 1, drop all ip outputs, go to DONE.
  - C words not yet written stay 0.
- DONE:
  - done_o_stb = 1 and c_out is stable.
  - On done_o_ack: done_o_stb = 0 on the next edge, go to IDLE.
  - err and c_out hold their values until the next start.
- Latency without timeout: N*N issues; each issue costs at least 1 DRAIN + 1 ISSUE + 1 WAIT_ACK + 1 WAIT_RES + 1 NEXT cycle plus the unit's compute time.
- Exactly one C write per (i, j). A result strobe held high is never captured twice, because DRAIN gates re-issue.
- Counters i and j are $clog2(N) bits wide (minimum 1). The timeout counter is $clog2(TIMEOUT_CYCLES)+1 bits wide.

Test Plan:
- Basic multiply. N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], bench inner_product model computes the integer dot product with 3-cycle latency -> c_out = [[19,22],[43,50]], done_o_stb = 1, err = 0, exactly 4 ip_row_stb rising edges.
- Issue order and packing. Same data -> issues in order (0,0),(0,1),(1,0),(1,1); on the (0,1) issue, ip_row = {2,1} and ip_column = {8,6} (word1 = 8, word0 = 6).
- Timeout. TIMEOUT_CYCLES=16, model never raises ip_out_stb on the first issue -> err = 1 and done_o_stb = 1 within 16 cycles of WAIT_RES entry; every c_out word is 0.
- Sticky result strobe. Model holds ip_out_stb high for 4 cycles after each result -> no ISSUE while it is high, each C word written once, final C still correct.
- Reset mid-operation. Assert rst low during WAIT_RES of pair (1,0) -> busy, done_o_stb, err, ip strobes and c_out are all 0 immediately; a restart then yields the correct C.
- Handshakes. start_i_stb held high throughout and done_o_ack delayed 5 cycles -> start_i_ack pulses once per run, done_o_stb stays high for 5 cycles, falls one cycle after ack, and a new run begins only from IDLE.
